// File: rtl/apb_ctrl_regs_n.sv
// apb_ctrl_regs_n: APB control/status register block for N MCDF slave channels.
// Holds per-channel enable/priority/packet-length controls, mirrors FIFO
// margins read-only, and raises a maskable interrupt on low-margin status.
module apb_ctrl_regs_n #(
    parameter int N           = 3,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int MARGIN_W    = 6,
    parameter int MARGIN_RST  = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_W-1:0]     paddr_i,
    input  logic                  pwr_i,
    input  logic                  psel_i,
    input  logic                  pen_i,
    input  logic [DATA_W-1:0]     pwdata_i,
    output logic [DATA_W-1:0]     prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [N*MARGIN_W-1:0] slv_margin_i,
    output logic [N-1:0]          slv_en_o,
    output logic [2*N-1:0]        slv_prio_o,
    output logic [3*N-1:0]        slv_pkglen_o,
    output logic                  irq_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    // Control register reset value: en=1, prio=3, pkglen=0.
    localparam logic [5:0] CTRL_RST = 6'h07;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [3:0]          wait_cnt;

    logic [5:0]          ctrl_q   [N];
    logic [MARGIN_W-1:0] margin_q [N];
    logic [N-1:0]        status_q;
    logic [N-1:0]        irq_en_q;
    logic [MARGIN_W-1:0] thresh_q;
    logic                irq_q;

    // Address decode fields (byte address, bits [1:0] ignored).
    logic [ADDR_W-1:0]   addr_hi;
    logic                hi_zero;
    logic [1:0]          region;
    logic [3:0]          sub;
    logic                idx_ok;

    logic                dec_err;
    logic [DATA_W-1:0]   rd_data;
    logic                complete;
    logic                wr_en;
    logic [N-1:0]        status_set;
    logic [N-1:0]        status_clr;

    logic                sig_unused;

    assign addr_hi = addr_q >> 8;
    assign hi_zero = (addr_hi == '0);
    assign region  = addr_q[7:6];
    assign sub     = addr_q[5:2];
    assign idx_ok  = (int'(sub) < N);

    assign pready_o  = (state == S_ACCESS) && (wait_cnt == 4'd0);
    assign complete  = pready_o && psel_i && pen_i;
    assign wr_en     = complete && wr_q && !dec_err;
    assign pslverr_o = pready_o && dec_err;
    assign prdata_o  = (pready_o && !wr_q && !dec_err) ? rd_data : '0;
    assign irq_o     = irq_q;

    // Bits of the bus that no register field consumes.
    assign sig_unused = ^{pwdata_i, paddr_i};

    // Decode the captured address into an error flag and the read mux.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        dec_err = 1'b1;
        rd_data = '0;
        if (hi_zero) begin
            case (region)
                2'd0: begin
                    if (idx_ok) begin
                        dec_err = 1'b0;
                        for (int i = 0; i < N; i++)
                            if (int'(sub) == i) rd_data = DATA_W'(ctrl_q[i]);
                    end
                end
                2'd1: begin
                    if (idx_ok && !wr_q) begin
                        dec_err = 1'b0;
                        for (int i = 0; i < N; i++)
                            if (int'(sub) == i) rd_data = DATA_W'(margin_q[i]);
                    end
                end
                2'd2: begin
                    case (sub)
                        4'd0: begin dec_err = 1'b0; rd_data = DATA_W'(status_q); end
                        4'd1: begin dec_err = 1'b0; rd_data = DATA_W'(irq_en_q); end
                        4'd2: begin dec_err = 1'b0; rd_data = DATA_W'(thresh_q); end
                        default: dec_err = 1'b1;
                    endcase
                end
                default: dec_err = 1'b1;
            endcase
        end
    end

    // APB next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (psel_i && !pen_i) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: if (!psel_i || complete) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM state, captured address/direction and wait-state counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state    <= S_IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && psel_i && !pen_i) begin
                addr_q   <= paddr_i;
                wr_q     <= pwr_i;
                wait_cnt <= 4'(WAIT_CYCLES);
            end else if (state == S_ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Per-channel CTRL registers and margin mirrors.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: these register arrays have architectural reset values, so each entry is reset explicitly.
            for (int i = 0; i < N; i++) begin
                ctrl_q[i]   <= CTRL_RST;
                margin_q[i] <= MARGIN_W'(MARGIN_RST);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                margin_q[i] <= slv_margin_i[i*MARGIN_W +: MARGIN_W];
                if (wr_en && region == 2'd0 && int'(sub) == i)
                    ctrl_q[i] <= pwdata_i[5:0];
            end
        end
    end

    // Sticky low-margin set and write-1-to-clear terms.
    always_comb begin
        status_set = '0;
        status_clr = '0;
        for (int i = 0; i < N; i++)
            status_set[i] = (margin_q[i] < thresh_q);
        if (wr_en && region == 2'd2 && sub == 4'd0)
            status_clr = pwdata_i[N-1:0];
    end

    // STATUS, IRQ_EN, THRESH and the registered interrupt.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_q <= '0;
            irq_en_q <= '0;
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            // Set wins over clear when both happen in the same cycle.
            status_q <= (status_q & ~status_clr) | status_set;
            if (wr_en && region == 2'd2 && sub == 4'd1)
                irq_en_q <= pwdata_i[N-1:0];
            if (wr_en && region == 2'd2 && sub == 4'd2)
                thresh_q <= pwdata_i[MARGIN_W-1:0];
            irq_q <= |(status_q & irq_en_q);
        end
    end

    // Fan the CTRL fields out to the slave/arbiter/formatter config buses.
    always_comb begin
        slv_en_o     = '0;
        slv_prio_o   = '0;
        slv_pkglen_o = '0;
        for (int i = 0; i < N; i++) begin
            slv_en_o[i]         = ctrl_q[i][0];
            slv_prio_o[2*i +: 2]   = ctrl_q[i][2:1];
            slv_pkglen_o[3*i +: 3] = ctrl_q[i][5:3];
        end
    end

endmodule

// File: tb/tb_apb_ctrl_regs_n.sv
// tb_apb_ctrl_regs_n: directed bench for apb_ctrl_regs_n. Instance u0 runs
// zero-wait APB, instance u1 inserts three wait states per ACCESS phase.
module tb_apb_ctrl_regs_n;

    localparam int N = 3;
    localparam int MW = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         paddr;
    logic               pwr;
    logic               pen;
    logic [31:0]        pwdata;
    logic               psel0, psel1;
    logic [N*MW-1:0]    margin;

    logic [31:0]        prdata0, prdata1;
    logic               pready0, pready1;
    logic               pslverr0, pslverr1;
    logic [N-1:0]       en0, en1;
    logic [2*N-1:0]     prio0, prio1;
    logic [3*N-1:0]     pkglen0, pkglen1;
    logic               irq0, irq1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb_ctrl_regs_n #(.N(N), .WAIT_CYCLES(0)) u0 (
        .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pwr_i(pwr), .psel_i(psel0),
        .pen_i(pen), .pwdata_i(pwdata), .prdata_o(prdata0), .pready_o(pready0),
        .pslverr_o(pslverr0), .slv_margin_i(margin), .slv_en_o(en0),
        .slv_prio_o(prio0), .slv_pkglen_o(pkglen0), .irq_o(irq0)
    );

    apb_ctrl_regs_n #(.N(N), .WAIT_CYCLES(3)) u1 (
        .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pwr_i(pwr), .psel_i(psel1),
        .pen_i(pen), .pwdata_i(pwdata), .prdata_o(prdata1), .pready_o(pready1),
        .pslverr_o(pslverr1), .slv_margin_i(margin), .slv_en_o(en1),
        .slv_prio_o(prio1), .slv_pkglen_o(pkglen1), .irq_o(irq1)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_sel(input int d, input logic v);
        if (d == 0) psel0 = v;
        else        psel1 = v;
    endtask

    // One complete APB transfer on instance d; samples on falling edges.
    task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int waits);
        bit done;
        done  = 0;
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        @(negedge clk);
        paddr = addr; pwr = wr; pwdata = wdata; pen = 1'b0; set_sel(d, 1'b1);
        @(negedge clk);
        pen = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if ((d == 0) ? pready0 : pready1) begin
                rdata = (d == 0) ? prdata0 : prdata1;
                err   = (d == 0) ? pslverr0 : pslverr1;
                done  = 1;
            end else begin
                waits++;
            end
        end
        if (!done) check("pready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        set_sel(d, 1'b0);
        pen = 1'b0;
    endtask

    task automatic rd(input int d, input string name, input logic [7:0] addr,
                      input logic [31:0] exp);
        logic [31:0] r; logic e; int w;
        apb_xfer(d, 1'b0, addr, 32'd0, r, e, w);
        check({name, "_data"}, r, exp);
        check({name, "_err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic wr(input int d, input logic [7:0] addr, input logic [31:0] data);
        logic [31:0] r; logic e; int w;
        apb_xfer(d, 1'b1, addr, data, r, e, w);
        check("wr_err", {31'd0, e}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          w;
        bit          seen;

        vecs[0]  = '{"rd_ctrl0",    1'b0, 8'h00, 32'h0,         32'h07, 1'b0};
        vecs[1]  = '{"rd_ctrl1",    1'b0, 8'h04, 32'h0,         32'h07, 1'b0};
        vecs[2]  = '{"rd_ctrl2",    1'b0, 8'h08, 32'h0,         32'h07, 1'b0};
        vecs[3]  = '{"rd_margin0",  1'b0, 8'h40, 32'h0,         32'h20, 1'b0};
        vecs[4]  = '{"rd_margin1",  1'b0, 8'h44, 32'h0,         32'h20, 1'b0};
        vecs[5]  = '{"rd_margin2",  1'b0, 8'h48, 32'h0,         32'h20, 1'b0};
        vecs[6]  = '{"wr_ctrl1",    1'b1, 8'h04, 32'hFFFF_FFFF, 32'h00, 1'b0};
        vecs[7]  = '{"rd_ctrl1_3f", 1'b0, 8'h04, 32'h0,         32'h3F, 1'b0};
        vecs[8]  = '{"wr_margin",   1'b1, 8'h40, 32'h12,        32'h00, 1'b1};
        vecs[9]  = '{"rd_ctrl3",    1'b0, 8'h0C, 32'h0,         32'h00, 1'b1};
        vecs[10] = '{"rd_0x90",     1'b0, 8'h90, 32'h0,         32'h00, 1'b1};
        vecs[11] = '{"rd_ctrl0_ok", 1'b0, 8'h00, 32'h0,         32'h07, 1'b0};
        vecs[12] = '{"rd_status",   1'b0, 8'h80, 32'h0,         32'h00, 1'b0};
        vecs[13] = '{"wr_irq_en",   1'b1, 8'h84, 32'hFFFF_FFFF, 32'h00, 1'b0};
        vecs[14] = '{"rd_irq_en",   1'b0, 8'h84, 32'h0,         32'h07, 1'b0};
        vecs[15] = '{"rd_0x8c",     1'b0, 8'h8C, 32'h0,         32'h00, 1'b1};

        rst = 1'b1; paddr = '0; pwr = 1'b0; pen = 1'b0; pwdata = '0;
        psel0 = 1'b0; psel1 = 1'b0;
        margin = {N{6'd32}};
        repeat (3) @(negedge clk);
        check("rst_pready",  {31'd0, pready0},  32'd0);
        check("rst_pslverr", {31'd0, pslverr0}, 32'd0);
        check("rst_prdata",  prdata0,           32'd0);
        check("rst_irq",     {31'd0, irq0},     32'd0);
        check("rst_en",      32'(en0),          32'h7);
        check("rst_prio",    32'(prio0),        32'h3F);
        check("rst_pkglen",  32'(pkglen0),      32'h0);
        rst = 1'b0;

        // Register map, reserved bits and error decoding on the zero-wait instance.
        foreach (vecs[i]) begin
            apb_xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, r, e, w);
            check({vecs[i].name, "_err"}, {31'd0, e}, {31'd0, vecs[i].exp_err});
            if (!vecs[i].wr) check({vecs[i].name, "_data"}, r, vecs[i].exp_rdata);
            check({vecs[i].name, "_waits"}, w, 0);
        end
        check("cfg_en",     32'(en0),     32'h7);
        check("cfg_prio",   32'(prio0),   32'h3F);
        check("cfg_pkglen", 32'(pkglen0), 32'h38);

        wr(0, 8'h88, 32'hFFFF_FFE0);
        rd(0, "rd_thresh", 8'h88, 32'h20);

        // Margin below threshold -> sticky status -> interrupt.
        wr(0, 8'h88, 32'd8);
        wr(0, 8'h84, 32'h1);
        check("irq_idle", {31'd0, irq0}, 32'd0);
        @(negedge clk);
        margin[MW-1:0] = 6'd5;
        @(negedge clk);
        @(negedge clk);
        check("irq_not_yet", {31'd0, irq0}, 32'd0);
        @(negedge clk);
        check("irq_set", {31'd0, irq0}, 32'd1);
        rd(0, "status_set", 8'h80, 32'h1);
        wr(0, 8'h80, 32'h1);
        rd(0, "status_sticky", 8'h80, 32'h1);
        check("irq_held", {31'd0, irq0}, 32'd1);
        margin[MW-1:0] = 6'd20;
        repeat (2) @(negedge clk);
        wr(0, 8'h80, 32'h1);
        rd(0, "status_clr", 8'h80, 32'h0);
        check("irq_clr", {31'd0, irq0}, 32'd0);

        // Wait states on the second instance.
        apb_xfer(1, 1'b0, 8'h44, 32'd0, r, e, w);
        check("w3_waits", w, 3);
        check("w3_data", r, 32'h20);
        check("w3_err", {31'd0, e}, 32'd0);

        // Abort a CTRL0 write in the second ACCESS cycle.
        @(negedge clk);
        paddr = 8'h00; pwr = 1'b1; pwdata = 32'h0; pen = 1'b0; psel1 = 1'b1;
        @(negedge clk);
        pen = 1'b1;
        @(negedge clk);
        check("abort_acc1", {31'd0, pready1}, 32'd0);
        @(negedge clk);
        check("abort_acc2", {31'd0, pready1}, 32'd0);
        psel1 = 1'b0; pen = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (pready1) seen = 1;
        end
        check("abort_no_pready", {31'd0, seen}, 32'd0);
        rd(1, "abort_ctrl0", 8'h00, 32'h07);
        check("abort_en", 32'(en1), 32'h7);

        // Reset during the ACCESS phase of a CTRL0 write.
        @(negedge clk);
        paddr = 8'h00; pwr = 1'b1; pwdata = 32'h0; pen = 1'b0; psel0 = 1'b1;
        @(negedge clk);
        pen = 1'b1;
        @(negedge clk);
        check("rst_mid_pready_before", {31'd0, pready0}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_pready", {31'd0, pready0}, 32'd0);
        @(negedge clk);
        rst = 1'b0; psel0 = 1'b0; pen = 1'b0;
        rd(0, "rst_mid_ctrl0", 8'h00, 32'h07);
        check("rst_mid_en", 32'(en0), 32'h7);
        rd(0, "rst_mid_ctrl1", 8'h04, 32'h07);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
